// File: rtl/pipe_decode_ctrl.sv
// RV32I decode stage for the five-stage core: registers control into ID/EX,
// detects RAW hazards against EX/MEM, selects forwarding and inserts bubbles.
module pipe_decode_ctrl #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned FWD_EN = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [31:0]       if_inst,
   input  logic [PC_W-1:0]   if_pc,
   output logic              id_ready,
   input  logic              ex_flush,
   input  logic [4:0]        mem_rd,
   input  logic              mem_wen,
   output logic              ex_valid,
   output logic [PC_W-1:0]   ex_pc,
   output logic [4:0]        ex_rd,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [2:0]        ex_funct3,
   output logic [XLEN-1:0]   ex_imm,
   output logic [3:0]        ex_alu_sel,
   output logic              ex_b_sel,
   output logic              ex_a_pc_sel,
   output logic              ex_is_branch,
   output logic              ex_is_jump,
   output logic              ex_mem_rd,
   output logic              ex_mem_wr,
   output logic              ex_reg_wen,
   output logic [1:0]        ex_wb_sel,
   output logic [1:0]        ex_fwd_a,
   output logic [1:0]        ex_fwd_b,
   output logic              ex_illegal,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [1:0] WB_MEM = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EXM = 2'd1;
   localparam logic [1:0] FWD_MWB = 2'd2;

   localparam bit FWD = (FWD_EN != 0);

   logic [6:0]      opcode;
   logic [4:0]      f_rd, f_rs1, f_rs2;
   logic [2:0]      f_funct3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   logic [4:0]      d_rs1;
   logic [XLEN-1:0] d_imm;
   logic [3:0]      d_alu_sel;
   logic            d_b_sel, d_a_pc_sel, d_is_branch, d_is_jump;
   logic            d_mem_rd, d_mem_wr, d_reg_wen, d_illegal;
   logic [1:0]      d_wb_sel;
   logic            rs1_use, rs2_use;

   logic            a_live, b_live;
   logic            ex_wr, ex_ld;
   logic            a_ex, a_mem, a_ld, b_ex, b_mem, b_ld;
   logic            hazard, stall, bubble;
   logic [1:0]      fwd_a, fwd_b;

   logic              ex_valid_q, ex_valid_d;
   logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
   logic [4:0]        ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   logic [2:0]        ex_funct3_q, ex_funct3_d;
   logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
   logic [3:0]        ex_alu_sel_q, ex_alu_sel_d;
   logic              ex_b_sel_q, ex_b_sel_d, ex_a_pc_sel_q, ex_a_pc_sel_d;
   logic              ex_is_branch_q, ex_is_branch_d, ex_is_jump_q, ex_is_jump_d;
   logic              ex_mem_rd_q, ex_mem_rd_d, ex_mem_wr_q, ex_mem_wr_d;
   logic              ex_reg_wen_q, ex_reg_wen_d, ex_illegal_q, ex_illegal_d;
   logic [1:0]        ex_wb_sel_q, ex_wb_sel_d;
   logic [1:0]        ex_fwd_a_q, ex_fwd_a_d, ex_fwd_b_q, ex_fwd_b_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   assign opcode   = if_inst[6:0];
   assign f_rd     = if_inst[11:7];
   assign f_funct3 = if_inst[14:12];
   assign f_rs1    = if_inst[19:15];
   assign f_rs2    = if_inst[24:20];

   assign imm_i = XLEN'($signed(if_inst[31:20]));
   assign imm_s = XLEN'($signed({if_inst[31:25], if_inst[11:7]}));
   assign imm_b = XLEN'($signed({if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({if_inst[31:12], 12'h000}));
   assign imm_j = XLEN'($signed({if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0}));

   // Opcode decode; SYSTEM is carried as an I-format no-writeback instruction.
   always_comb begin
      d_rs1       = f_rs1;
      d_imm       = '0;
      d_alu_sel   = '0;
      d_b_sel     = 1'b0;
      d_a_pc_sel  = 1'b0;
      d_is_branch = 1'b0;
      d_is_jump   = 1'b0;
      d_mem_rd    = 1'b0;
      d_mem_wr    = 1'b0;
      d_reg_wen   = 1'b0;
      d_illegal   = 1'b0;
      d_wb_sel    = WB_MEM;
      rs1_use     = 1'b0;
      rs2_use     = 1'b0;
      unique case (opcode)
         OPC_LUI: begin
            d_rs1 = '0; d_imm = imm_u; d_b_sel = 1'b1; d_reg_wen = 1'b1; d_wb_sel = WB_ALU;
         end
         OPC_AUIPC: begin
            d_imm = imm_u; d_b_sel = 1'b1; d_a_pc_sel = 1'b1; d_reg_wen = 1'b1; d_wb_sel = WB_ALU;
         end
         OPC_JAL: begin
            d_imm = imm_j; d_b_sel = 1'b1; d_a_pc_sel = 1'b1; d_is_jump = 1'b1;
            d_reg_wen = 1'b1; d_wb_sel = WB_PC4;
         end
         OPC_JALR: begin
            d_imm = imm_i; d_b_sel = 1'b1; d_is_jump = 1'b1; d_reg_wen = 1'b1;
            d_wb_sel = WB_PC4; rs1_use = 1'b1;
         end
         OPC_BRANCH: begin
            d_imm = imm_b; d_b_sel = 1'b1; d_a_pc_sel = 1'b1; d_is_branch = 1'b1;
            rs1_use = 1'b1; rs2_use = 1'b1;
         end
         OPC_LOAD: begin
            d_imm = imm_i; d_b_sel = 1'b1; d_mem_rd = 1'b1; d_reg_wen = 1'b1;
            d_wb_sel = WB_MEM; rs1_use = 1'b1;
         end
         OPC_STORE: begin
            d_imm = imm_s; d_b_sel = 1'b1; d_mem_wr = 1'b1; rs1_use = 1'b1; rs2_use = 1'b1;
         end
         OPC_OPIMM: begin
            d_imm = imm_i; d_b_sel = 1'b1; d_reg_wen = 1'b1; d_wb_sel = WB_ALU; rs1_use = 1'b1;
            d_alu_sel = {(f_funct3 == 3'b101) & if_inst[30], f_funct3};
         end
         OPC_OP: begin
            d_alu_sel = {if_inst[30], f_funct3}; d_reg_wen = 1'b1; d_wb_sel = WB_ALU;
            rs1_use = 1'b1; rs2_use = 1'b1;
         end
         OPC_SYSTEM: begin
            d_imm = imm_i; d_b_sel = 1'b1; rs1_use = 1'b1;
         end
         default: d_illegal = 1'b1;
      endcase
      if (f_rd == 5'd0) d_reg_wen = 1'b0;
   end

   // Source matches against EX and MEM producers; x0 and unused sources never match.
   always_comb begin
      a_live = rs1_use & (f_rs1 != 5'd0);
      b_live = rs2_use & (f_rs2 != 5'd0);
      ex_wr  = ex_valid_q & ex_reg_wen_q;
      ex_ld  = ex_valid_q & ex_mem_rd_q & (ex_rd_q != 5'd0);
      a_ex   = a_live & ex_wr & (ex_rd_q == f_rs1);
      b_ex   = b_live & ex_wr & (ex_rd_q == f_rs2);
      a_ld   = a_live & ex_ld & (ex_rd_q == f_rs1);
      b_ld   = b_live & ex_ld & (ex_rd_q == f_rs2);
      a_mem  = a_live & mem_wen & (mem_rd == f_rs1);
      b_mem  = b_live & mem_wen & (mem_rd == f_rs2);
      fwd_a  = FWD_RF;
      fwd_b  = FWD_RF;
      if (FWD) begin
         hazard = a_ld | b_ld;
         if (a_ex)       fwd_a = FWD_EXM;
         else if (a_mem) fwd_a = FWD_MWB;
         if (b_ex)       fwd_b = FWD_EXM;
         else if (b_mem) fwd_b = FWD_MWB;
      end else begin
         hazard = a_ex | a_mem | b_ex | b_mem;
      end
      stall    = if_valid & hazard & ~ex_flush;
      bubble   = ex_flush | stall | ~if_valid;
      id_ready = ~stall;
   end

   // Next ID/EX contents: a bubble clears every control field.
   always_comb begin
      ex_valid_d     = 1'b0;
      ex_pc_d        = '0;
      ex_rd_d        = '0;
      ex_rs1_d       = '0;
      ex_rs2_d       = '0;
      ex_funct3_d    = '0;
      ex_imm_d       = '0;
      ex_alu_sel_d   = '0;
      ex_b_sel_d     = 1'b0;
      ex_a_pc_sel_d  = 1'b0;
      ex_is_branch_d = 1'b0;
      ex_is_jump_d   = 1'b0;
      ex_mem_rd_d    = 1'b0;
      ex_mem_wr_d    = 1'b0;
      ex_reg_wen_d   = 1'b0;
      ex_wb_sel_d    = '0;
      ex_fwd_a_d     = '0;
      ex_fwd_b_d     = '0;
      ex_illegal_d   = 1'b0;
      stall_cnt_d    = stall_cnt_q;
      if (!bubble) begin
         ex_valid_d     = 1'b1;
         ex_pc_d        = if_pc;
         ex_rd_d        = f_rd;
         ex_rs1_d       = d_rs1;
         ex_rs2_d       = f_rs2;
         ex_funct3_d    = f_funct3;
         ex_imm_d       = d_imm;
         ex_alu_sel_d   = d_alu_sel;
         ex_b_sel_d     = d_b_sel;
         ex_a_pc_sel_d  = d_a_pc_sel;
         ex_is_branch_d = d_is_branch;
         ex_is_jump_d   = d_is_jump;
         ex_mem_rd_d    = d_mem_rd;
         ex_mem_wr_d    = d_mem_wr;
         ex_reg_wen_d   = d_reg_wen;
         ex_wb_sel_d    = d_wb_sel;
         ex_fwd_a_d     = fwd_a;
         ex_fwd_b_d     = fwd_b;
         ex_illegal_d   = d_illegal;
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_valid_q     <= 1'b0;
         ex_pc_q        <= '0;
         ex_rd_q        <= '0;
         ex_rs1_q       <= '0;
         ex_rs2_q       <= '0;
         ex_funct3_q    <= '0;
         ex_imm_q       <= '0;
         ex_alu_sel_q   <= '0;
         ex_b_sel_q     <= 1'b0;
         ex_a_pc_sel_q  <= 1'b0;
         ex_is_branch_q <= 1'b0;
         ex_is_jump_q   <= 1'b0;
         ex_mem_rd_q    <= 1'b0;
         ex_mem_wr_q    <= 1'b0;
         ex_reg_wen_q   <= 1'b0;
         ex_wb_sel_q    <= '0;
         ex_fwd_a_q     <= '0;
         ex_fwd_b_q     <= '0;
         ex_illegal_q   <= 1'b0;
         stall_cnt_q    <= '0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_pc_q        <= ex_pc_d;
         ex_rd_q        <= ex_rd_d;
         ex_rs1_q       <= ex_rs1_d;
         ex_rs2_q       <= ex_rs2_d;
         ex_funct3_q    <= ex_funct3_d;
         ex_imm_q       <= ex_imm_d;
         ex_alu_sel_q   <= ex_alu_sel_d;
         ex_b_sel_q     <= ex_b_sel_d;
         ex_a_pc_sel_q  <= ex_a_pc_sel_d;
         ex_is_branch_q <= ex_is_branch_d;
         ex_is_jump_q   <= ex_is_jump_d;
         ex_mem_rd_q    <= ex_mem_rd_d;
         ex_mem_wr_q    <= ex_mem_wr_d;
         ex_reg_wen_q   <= ex_reg_wen_d;
         ex_wb_sel_q    <= ex_wb_sel_d;
         ex_fwd_a_q     <= ex_fwd_a_d;
         ex_fwd_b_q     <= ex_fwd_b_d;
         ex_illegal_q   <= ex_illegal_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_pc        = ex_pc_q;
   assign ex_rd        = ex_rd_q;
   assign ex_rs1       = ex_rs1_q;
   assign ex_rs2       = ex_rs2_q;
   assign ex_funct3    = ex_funct3_q;
   assign ex_imm       = ex_imm_q;
   assign ex_alu_sel   = ex_alu_sel_q;
   assign ex_b_sel     = ex_b_sel_q;
   assign ex_a_pc_sel  = ex_a_pc_sel_q;
   assign ex_is_branch = ex_is_branch_q;
   assign ex_is_jump   = ex_is_jump_q;
   assign ex_mem_rd    = ex_mem_rd_q;
   assign ex_mem_wr    = ex_mem_wr_q;
   assign ex_reg_wen   = ex_reg_wen_q;
   assign ex_wb_sel    = ex_wb_sel_q;
   assign ex_fwd_a     = ex_fwd_a_q;
   assign ex_fwd_b     = ex_fwd_b_q;
   assign ex_illegal   = ex_illegal_q;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Bench for pipe_decode_ctrl: a forwarding instance and a no-forwarding instance
// (narrow stall counter) share stimulus and are scored against a reference model.
module tb_pipe_decode_ctrl;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        bsel, apc, br, jmp, mrd, mwr, wen;
      logic [1:0]  wb, fa, fb;
      logic        ill;
   } ex_t;

   logic        clock = 1'b0;
   logic        reset, if_valid, ex_flush, mem_wen;
   logic [31:0] if_inst, if_pc;
   logic [4:0]  mem_rd;

   logic        o_rdy [2];
   logic        o_valid [2];
   logic [31:0] o_pc [2];
   logic [4:0]  o_rd [2], o_rs1 [2], o_rs2 [2];
   logic [2:0]  o_f3 [2];
   logic [31:0] o_imm [2];
   logic [3:0]  o_alu [2];
   logic        o_bsel [2], o_apc [2], o_br [2], o_jmp [2], o_mrd [2], o_mwr [2], o_wen [2];
   logic [1:0]  o_wb [2], o_fa [2], o_fb [2];
   logic        o_ill [2];
   logic [15:0] o_cnt [2];

   ex_t         m [2];
   int unsigned mcnt [2];
   logic        rdy_seen [2];
   int          n_total = 0;
   int          n_bad = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned CW = (g == 0) ? 16 : 3;
      logic [CW-1:0] cnt;
      pipe_decode_ctrl #(.XLEN(32), .PC_W(32), .FWD_EN((g == 0) ? 1 : 0), .CNT_W(CW)) u_dut (
         .clock(clock), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
         .id_ready(o_rdy[g]), .ex_flush(ex_flush), .mem_rd(mem_rd), .mem_wen(mem_wen),
         .ex_valid(o_valid[g]), .ex_pc(o_pc[g]), .ex_rd(o_rd[g]), .ex_rs1(o_rs1[g]),
         .ex_rs2(o_rs2[g]), .ex_funct3(o_f3[g]), .ex_imm(o_imm[g]), .ex_alu_sel(o_alu[g]),
         .ex_b_sel(o_bsel[g]), .ex_a_pc_sel(o_apc[g]), .ex_is_branch(o_br[g]),
         .ex_is_jump(o_jmp[g]), .ex_mem_rd(o_mrd[g]), .ex_mem_wr(o_mwr[g]),
         .ex_reg_wen(o_wen[g]), .ex_wb_sel(o_wb[g]), .ex_fwd_a(o_fa[g]), .ex_fwd_b(o_fb[g]),
         .ex_illegal(o_ill[g]), .stall_cnt(cnt));
      assign o_cnt[g] = 16'(cnt);
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned cnt_max(input int k);
      return (k == 0) ? 32'd65535 : 32'd7;
   endfunction

   // Reference decode: immediates built arithmetically from the instruction word.
   function automatic ex_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                      output logic u1, output logic u2);
      ex_t         e;
      int          s;
      logic [31:0] sx, imm_i;
      logic [2:0]  f3;
      e = '0; u1 = 1'b0; u2 = 1'b0;
      s = i;
      sx = 32'(s >>> 31);
      imm_i = 32'(s >>> 20);
      f3 = i[14:12];
      e.valid = 1'b1; e.pc = pc; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = f3;
      case (i[6:0])
         7'b0110111: begin e.rs1 = 5'd0; e.imm = i & 32'hFFFFF000; e.bsel = 1; e.wen = 1; e.wb = 1; end
         7'b0010111: begin e.imm = i & 32'hFFFFF000; e.bsel = 1; e.apc = 1; e.wen = 1; e.wb = 1; end
         7'b1101111: begin
            e.imm = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            e.bsel = 1; e.apc = 1; e.jmp = 1; e.wen = 1; e.wb = 2;
         end
         7'b1100111: begin e.imm = imm_i; e.bsel = 1; e.jmp = 1; e.wen = 1; e.wb = 2; u1 = 1; end
         7'b1100011: begin
            e.imm = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            e.bsel = 1; e.apc = 1; e.br = 1; u1 = 1; u2 = 1;
         end
         7'b0000011: begin e.imm = imm_i; e.bsel = 1; e.mrd = 1; e.wen = 1; e.wb = 0; u1 = 1; end
         7'b0100011: begin
            e.imm = (imm_i & ~32'h1F) | 32'(i[11:7]); e.bsel = 1; e.mwr = 1; u1 = 1; u2 = 1;
         end
         7'b0010011: begin
            e.imm = imm_i; e.bsel = 1; e.wen = 1; e.wb = 1; u1 = 1;
            e.alu = {(f3 == 3'd5) ? i[30] : 1'b0, f3};
         end
         7'b0110011: begin e.alu = {i[30], f3}; e.wen = 1; e.wb = 1; u1 = 1; u2 = 1; end
         7'b1110011: begin e.imm = imm_i; e.bsel = 1; u1 = 1; end
         default:    e.ill = 1;
      endcase
      if (e.rd == 5'd0) e.wen = 1'b0;
      return e;
   endfunction

   task automatic check_outputs(input string tag);
      ex_t g;
      for (int k = 0; k < 2; k++) begin
         g = '{valid: o_valid[k], pc: o_pc[k], rd: o_rd[k], rs1: o_rs1[k], rs2: o_rs2[k],
               f3: o_f3[k], imm: o_imm[k], alu: o_alu[k], bsel: o_bsel[k], apc: o_apc[k],
               br: o_br[k], jmp: o_jmp[k], mrd: o_mrd[k], mwr: o_mwr[k], wen: o_wen[k],
               wb: o_wb[k], fa: o_fa[k], fb: o_fb[k], ill: o_ill[k]};
         check_eq($sformatf("%s_ex%0d", tag, k), 128'(g), 128'(m[k]));
         check_eq($sformatf("%s_cnt%0d", tag, k), 128'(o_cnt[k]), 128'(mcnt[k]));
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < 2; k++) begin m[k] = '0; mcnt[k] = 0; end
   endtask

   // One ID cycle: drive at negedge, score id_ready, advance model, score registers.
   task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic fl, input logic [4:0] mr, input logic mw);
      ex_t  d, nxt;
      logic u1, u2, a_ex, a_mem, a_ld, b_ex, b_mem, b_ld, haz, stl;
      logic [4:0] r1, r2;
      @(negedge clock);
      if_valid = v; if_inst = inst; if_pc = pc; ex_flush = fl; mem_rd = mr; mem_wen = mw;
      #1;
      d  = ref_decode(inst, pc, u1, u2);
      r1 = inst[19:15];
      r2 = inst[24:20];
      for (int k = 0; k < 2; k++) begin
         a_ex  = u1 && r1 != 0 && m[k].valid && m[k].wen && m[k].rd == r1;
         b_ex  = u2 && r2 != 0 && m[k].valid && m[k].wen && m[k].rd == r2;
         a_ld  = u1 && r1 != 0 && m[k].valid && m[k].mrd && m[k].rd == r1;
         b_ld  = u2 && r2 != 0 && m[k].valid && m[k].mrd && m[k].rd == r2;
         a_mem = u1 && r1 != 0 && mw && mr == r1;
         b_mem = u2 && r2 != 0 && mw && mr == r2;
         haz = (k == 0) ? (a_ld || b_ld) : (a_ex || a_mem || b_ex || b_mem);
         stl = v && haz && !fl;
         rdy_seen[k] = o_rdy[k];
         check_eq($sformatf("id_ready%0d", k), 128'(o_rdy[k]), 128'(!stl));
         nxt = '0;
         if (v && !fl && !stl) begin
            nxt = d;
            if (k == 0) begin
               nxt.fa = a_ex ? 2'd1 : (a_mem ? 2'd2 : 2'd0);
               nxt.fb = b_ex ? 2'd1 : (b_mem ? 2'd2 : 2'd0);
            end
         end
         if (stl && mcnt[k] < cnt_max(k)) mcnt[k]++;
         m[k] = nxt;
      end
      @(posedge clock);
      #1;
      check_outputs("step");
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; if_valid = 1'b0; ex_flush = 1'b0; mem_wen = 1'b0; mem_rd = '0;
      @(posedge clock);
      #1;
      clear_model();
      check_outputs("reset");
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] ops [10];
      logic [31:0] inst;
      ops = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03, 32'h23, 32'h13, 32'h33, 32'h73};
      reset = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0; ex_flush = 1'b0;
      mem_rd = '0; mem_wen = 1'b0;
      clear_model();
      do_reset();

      // Reset asserted while a load-use stall is active.
      step(1, 32'h0000A283, 32'h100, 0, 5'd0, 0);
      @(negedge clock);
      if_valid = 1'b1; if_inst = 32'h00228333; if_pc = 32'h104; reset = 1'b1;
      #1;
      check_eq("pre_rst_stall", 128'(o_rdy[0]), 128'(0));
      @(posedge clock);
      #1;
      clear_model();
      check_outputs("rst_mid_stall");
      check_eq("rst_rdy0", 128'(o_rdy[0]), 128'(1));
      check_eq("rst_rdy1", 128'(o_rdy[1]), 128'(1));
      @(negedge clock);
      reset = 1'b0;

      // EX->EX forwarding of addi into add.
      do_reset();
      step(1, 32'h00500193, 32'h0, 0, 5'd0, 0);
      step(1, 32'h00318233, 32'h4, 0, 5'd0, 0);
      check_eq("fw_rdy", 128'(rdy_seen[0]), 128'(1));
      check_eq("fw_valid", 128'(o_valid[0]), 128'(1));
      check_eq("fw_a", 128'(o_fa[0]), 128'(1));
      check_eq("fw_b", 128'(o_fb[0]), 128'(1));
      check_eq("fw_alu", 128'(o_alu[0]), 128'(0));

      // Load-use: one bubble, then MEM/WB forward.
      do_reset();
      step(1, 32'h0000A283, 32'h10, 0, 5'd0, 0);
      step(1, 32'h00228333, 32'h14, 0, 5'd0, 0);
      check_eq("lu_rdy_stall", 128'(rdy_seen[0]), 128'(0));
      check_eq("lu_bubble", 128'(o_valid[0]), 128'(0));
      step(1, 32'h00228333, 32'h14, 0, 5'd5, 1);
      check_eq("lu_rdy_go", 128'(rdy_seen[0]), 128'(1));
      check_eq("lu_valid", 128'(o_valid[0]), 128'(1));
      check_eq("lu_fa", 128'(o_fa[0]), 128'(2));
      check_eq("lu_fb", 128'(o_fb[0]), 128'(0));
      check_eq("lu_cnt", 128'(o_cnt[0]), 128'(1));

      // Backward branch immediate.
      step(1, 32'hFE208CE3, 32'h20, 0, 5'd0, 0);
      check_eq("br_imm", 128'(o_imm[0]), 128'(32'hFFFFFFF8));
      check_eq("br_is", 128'(o_br[0]), 128'(1));
      check_eq("br_apc", 128'(o_apc[0]), 128'(1));
      check_eq("br_wen", 128'(o_wen[0]), 128'(0));

      // Flush overrides a load-use stall.
      do_reset();
      step(1, 32'h0000A283, 32'h30, 0, 5'd0, 0);
      step(1, 32'h00228333, 32'h34, 1, 5'd0, 0);
      check_eq("fl_rdy", 128'(rdy_seen[0]), 128'(1));
      check_eq("fl_valid", 128'(o_valid[0]), 128'(0));
      check_eq("fl_cnt", 128'(o_cnt[0]), 128'(0));

      // No forwarding: dependent add waits for the producer to reach WB.
      do_reset();
      step(1, 32'h00500193, 32'h40, 0, 5'd0, 0);
      step(1, 32'h00318233, 32'h44, 0, 5'd0, 0);
      check_eq("nf_rdy_ex", 128'(rdy_seen[1]), 128'(0));
      step(1, 32'h00318233, 32'h44, 0, 5'd3, 1);
      check_eq("nf_rdy_mem", 128'(rdy_seen[1]), 128'(0));
      step(1, 32'h00318233, 32'h44, 0, 5'd0, 0);
      check_eq("nf_rdy_go", 128'(rdy_seen[1]), 128'(1));
      check_eq("nf_valid", 128'(o_valid[1]), 128'(1));
      check_eq("nf_fa", 128'(o_fa[1]), 128'(0));
      check_eq("nf_fb", 128'(o_fb[1]), 128'(0));
      check_eq("nf_cnt", 128'(o_cnt[1]), 128'(2));

      // Randomized traffic over a small register window to provoke hazards.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         inst = $urandom;
         if ($urandom_range(0, 11) != 0) inst[6:0] = ops[$urandom_range(0, 9)][6:0];
         inst[11:7]  = 5'($urandom_range(0, 3));
         inst[19:15] = 5'($urandom_range(0, 3));
         inst[24:20] = 5'($urandom_range(0, 3));
         step(($urandom_range(0, 9) != 0), inst, $urandom & 32'hFFFFFFFC,
              ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_decode_ctrl.md
Name: pipe_decode_ctrl

Overview:
Pipelined successor to the single-cycle control decoder: decodes the RV32I instruction held in the IF/ID latch and registers all control into an ID/EX pipeline register.
- Detects RAW hazards against the instructions in EX and MEM.
- Generates forwarding selects, inserts bubbles on load-use or unforwardable hazards, and kills the ID instruction on an EX branch/jump redirect.
- Sits between the IF/ID latch and the EX stage of the five-stage core.

Parameters:
- XLEN, 32, data/immediate width; immediates sign-extended to XLEN.
- PC_W, 32, PC width.
- FWD_EN, 1, 1 = EX/MEM and MEM/WB forwarding present; 0 = stall until producer reaches WB.
- CNT_W, 16, width of saturating stall counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_valid  in  1  IF/ID holds a valid instruction
- if_inst  in  32  instruction in IF/ID
- if_pc  in  PC_W  PC of if_inst
- id_ready  out  1  combinational; 1 = ID consumes if_inst this cycle (0 = hold IF/ID and PC)
- ex_flush  in  1  EX resolved taken branch/jump; kill ID
- mem_rd  in  5  rd of instruction now in MEM
- mem_wen  in  1  MEM instruction writes rd
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc  out  PC_W  registered PC
- ex_rd, ex_rs1, ex_rs2  out  5 each  registered register indices
- ex_funct3  out  3  registered funct3 (branch type, mem size, unsigned)
- ex_imm  out  XLEN  decoded immediate
- ex_alu_sel  out  4  {alt bit, funct3}; 0 = add
- ex_b_sel  out  1  0 = rs2, 1 = imm
- ex_a_pc_sel  out  1  0 = rs1, 1 = pc
- ex_is_branch, ex_is_jump  out  1 each
- ex_mem_rd, ex_mem_wr  out  1 each  load / store
- ex_reg_wen  out  1  writes rd (forced 0 when rd = x0)
- ex_wb_sel  out  2  0 = mem, 1 = alu, 2 = pc+4
- ex_fwd_a, ex_fwd_b  out  2 each  0 = regfile, 1 = EX/MEM result, 2 = MEM/WB result
- ex_illegal  out  1  unrecognised opcode
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: every ex_* output is 0 and stall_cnt is 0. Reset has priority over all other inputs, including mid-stall.
- Decoded opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, SYSTEM 1110011.
- Any other opcode sets ex_illegal=1 with reg_wen=0 and mem_wr=0.
- Immediates use standard I/S/B/U/J layouts. B bit 11 = inst[7].
- alu_sel[3] = inst[30] for OP, and for OP-IMM when funct3=101. Otherwise alu_sel[3] = 0.
- LUI: a = x0 (rs1 forced 0). AUIPC, JAL and BRANCH: a_pc_sel=1. JAL and JALR: wb_sel=2. LOAD: wb_sel=0.
- Source usage:
  - rs1 used by R, I, S, B, JALR.
  - rs2 used by R, S, B.
  - Unused sources and x0 never cause a hazard or a forward.
- Hazard, FWD_EN=1: stall when EX holds a valid load with rd≠0 matching a used source.
- Hazard, FWD_EN=0: stall when a valid EX writer (ex_reg_wen) or a MEM writer (mem_wen) has rd matching a used source.
  - The register file is write-before-read, so WB is never a hazard.
- Forward select, computed in ID and registered:
  - 1 if the current EX writer matches (it will be in MEM next cycle).
  - Else 2 if the MEM writer matches.
  - Else 0.
  - EX match has priority. Always 0 when FWD_EN=0.
- stall = if_valid & hazard & ~ex_flush.
- id_ready = ~stall.
- Next ID/EX:
  - ex_flush=1, stall=1 or if_valid=0: bubble (ex_valid=0, all control 0).
  - Otherwise: decoded instruction, ex_valid=1.
- Flush has priority over stall; a flushed cycle is not counted.
- stall_cnt increments on each stall cycle and saturates at all-ones.
- Latency: one cycle from if_inst to ex_*. A load-use costs one bubble. With FWD_EN=0 the dependent instruction waits up to 2 cycles.

Test Plan:
- Reset asserted while a stall is active -> next cycle all ex_* are 0, stall_cnt=0, id_ready=1.
- FWD_EN=1: 0x00500193 (addi x3,x0,5) then 0x00318233 (add x4,x3,x3) -> no stall; add enters EX with ex_fwd_a=ex_fwd_b=1, ex_alu_sel=0.
- FWD_EN=1: 0x0000A283 (lw x5,0(x1)) then 0x00228333 (add x6,x5,x2) -> id_ready=0 for exactly one cycle, one bubble; add then in EX with ex_fwd_a=2, ex_fwd_b=0; stall_cnt=1.
- 0xFE208CE3 (beq x1,x2,-8) -> ex_imm=0xFFFFFFF8, ex_is_branch=1, ex_a_pc_sel=1, ex_reg_wen=0.
- ex_flush=1 in the same cycle as a load-use hazard -> id_ready=1, next ex_valid=0, stall_cnt unchanged.
- FWD_EN=0: addi x3 then add x4,x3,x3 -> id_ready=0 for 2 cycles; add enters EX with ex_fwd_a=ex_fwd_b=0; stall_cnt=2.
